// File: rtl/if_ctrl.sv
// Instruction fetch controller: issues one ROM request at a time, returns
// {instruction, pc} to the decode side through a valid/ready output slot
// backed by a one-entry skid buffer, and redirects on execute-stage jumps.
//
// state | meaning
// IDLE  | one cycle after reset release, nothing issued yet
// REQ   | rom_req_out high, holding rom_addr_out until the ROM acks
// WAIT  | one request outstanding, waiting for its response
// FULL  | response parked in the skid entry, output slot still blocked
// DRAIN | outstanding response belongs to a pre-jump stream, drop it
module if_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req_out,
  output logic [31:0] rom_addr_out,
  input  logic        rom_ack_in,
  input  logic        rom_rvalid_in,
  input  logic [31:0] rom_rdata_in,
  input  logic        jump_flag_in,
  input  logic [31:0] jump_addr_in,
  input  logic        id_ready_in,
  output logic        if_valid_out,
  output logic [31:0] if_instr_out,
  output logic [31:0] if_pc_out
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FULL  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tag;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  state_t      w_state_nx;
  logic [31:0] w_pc_nx;
  logic [31:0] w_tag_nx;
  logic        w_out_valid_nx;
  logic [31:0] w_out_instr_nx;
  logic [31:0] w_out_pc_nx;
  logic        w_skid_valid_nx;
  logic [31:0] w_skid_instr_nx;
  logic [31:0] w_skid_pc_nx;

  logic        w_slot_free;
  logic [31:0] w_pc_inc;
  logic [31:0] w_jump_tgt;
  logic        w_unused_jump_lsb;

  // The output slot can take new data if empty or being drained this cycle.
  assign w_slot_free = ~r_out_valid | id_ready_in;
  // Fetch addresses are word aligned; natural 32-bit wrap past 0xFFFF_FFFC.
  assign w_pc_inc    = r_pc + 32'd4;
  assign w_jump_tgt  = {jump_addr_in[31:2], 2'b00};
  assign w_unused_jump_lsb = |jump_addr_in[1:0];

  assign rom_req_out  = (r_state == ST_REQ);
  assign rom_addr_out = (r_state == ST_REQ) ? r_pc : 32'd0;
  assign if_valid_out = r_out_valid;
  assign if_instr_out = r_out_valid ? r_out_instr : NOP_INSTR;
  assign if_pc_out    = r_out_pc;

  // Next-state, fetch pointer, output slot and skid updates; jump overrides last.
  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_tag_nx        = r_tag;
    w_out_valid_nx  = r_out_valid & ~id_ready_in;
    w_out_instr_nx  = r_out_instr;
    w_out_pc_nx     = r_out_pc;
    w_skid_valid_nx = r_skid_valid;
    w_skid_instr_nx = r_skid_instr;
    w_skid_pc_nx    = r_skid_pc;

    case (r_state)
      ST_IDLE: begin
        w_state_nx = ST_REQ;
      end
      ST_REQ: begin
        if (rom_ack_in) begin
          w_pc_nx    = w_pc_inc;
          w_tag_nx   = r_pc;
          w_state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rom_rvalid_in) begin
          if (w_slot_free) begin
            w_out_valid_nx = 1'b1;
            w_out_instr_nx = rom_rdata_in;
            w_out_pc_nx    = r_tag;
          end else begin
            w_skid_valid_nx = 1'b1;
            w_skid_instr_nx = rom_rdata_in;
            w_skid_pc_nx    = r_tag;
          end
          w_state_nx = w_slot_free ? ST_REQ : ST_FULL;
        end
      end
      ST_FULL: begin
        // Output is occupied on entry, so it only frees up via a transfer.
        if (id_ready_in && r_skid_valid) begin
          w_out_valid_nx  = 1'b1;
          w_out_instr_nx  = r_skid_instr;
          w_out_pc_nx     = r_skid_pc;
          w_skid_valid_nx = 1'b0;
          w_state_nx      = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (rom_rvalid_in) begin
          w_state_nx = ST_REQ;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    // A concurrent output transfer has already been counted by the
    // consumer; everything still buffered is from the old stream.
    if (jump_flag_in) begin
      w_pc_nx         = w_jump_tgt;
      w_out_valid_nx  = 1'b0;
      w_skid_valid_nx = 1'b0;
      case (r_state)
        ST_REQ:   w_state_nx = rom_ack_in    ? ST_DRAIN : ST_REQ;
        ST_WAIT:  w_state_nx = rom_rvalid_in ? ST_REQ   : ST_DRAIN;
        ST_DRAIN: w_state_nx = rom_rvalid_in ? ST_REQ   : ST_DRAIN;
        default:  w_state_nx = ST_REQ;
      endcase
    end
  end

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_tag        <= 32'd0;
      r_out_valid  <= 1'b0;
      r_out_instr  <= NOP_INSTR;
      r_out_pc     <= 32'd0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_tag        <= w_tag_nx;
      r_out_valid  <= w_out_valid_nx;
      r_out_instr  <= w_out_instr_nx;
      r_out_pc     <= w_out_pc_nx;
      r_skid_valid <= w_skid_valid_nx;
      r_skid_instr <= w_skid_instr_nx;
      r_skid_pc    <= w_skid_pc_nx;
    end
  end

endmodule

// File: tb/tb_if_ctrl.sv
// Bench for if_ctrl: directed scenarios plus a randomized run against a
// stream-level reference (expected fetch address and expected delivered pc).
module tb_if_ctrl;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ack_in = 1'b0;
  logic        rom_rvalid_in = 1'b0;
  logic [31:0] rom_rdata_in = 32'd0;
  logic        jump_flag_in = 1'b0;
  logic [31:0] jump_addr_in = 32'd0;
  logic        id_ready_in = 1'b0;

  logic        rom_req_out;
  logic [31:0] rom_addr_out;
  logic        if_valid_out;
  logic [31:0] if_instr_out;
  logic [31:0] if_pc_out;

  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_valid;
  logic [31:0] wr_instr;
  logic [31:0] wr_pc;

  if_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst(rst),
    .rom_req_out(rom_req_out), .rom_addr_out(rom_addr_out),
    .rom_ack_in(rom_ack_in), .rom_rvalid_in(rom_rvalid_in), .rom_rdata_in(rom_rdata_in),
    .jump_flag_in(jump_flag_in), .jump_addr_in(jump_addr_in), .id_ready_in(id_ready_in),
    .if_valid_out(if_valid_out), .if_instr_out(if_instr_out), .if_pc_out(if_pc_out)
  );

  if_ctrl #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .rom_req_out(wr_req), .rom_addr_out(wr_addr),
    .rom_ack_in(rom_ack_in), .rom_rvalid_in(rom_rvalid_in), .rom_rdata_in(rom_rdata_in),
    .jump_flag_in(jump_flag_in), .jump_addr_in(jump_addr_in), .id_ready_in(id_ready_in),
    .if_valid_out(wr_valid), .if_instr_out(wr_instr), .if_pc_out(wr_pc)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_xfer  = 0;

  // ROM behaviour
  bit          rom_pend;
  logic [31:0] rom_pend_addr;
  int          rom_cnt;

  // stimulus configuration
  bit          zero_wait = 1'b1;
  int          rom_lat = 0;
  int          ack_pct = 100;
  int          ready_mode = 1;
  int          ready_pct = 70;
  bit          jump_force = 1'b0;
  logic [31:0] jump_tgt = 32'd0;
  int          jump_pct = 0;
  bit          inject_rvalid = 1'b0;

  // reference stream
  logic [31:0] exp_req_addr;
  logic [31:0] exp_out_pc;
  bit          prev_hold;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F1E};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_req_addr = RST_PC;
    exp_out_pc   = RST_PC;
    prev_hold    = 1'b0;
    rom_pend     = 1'b0;
    rom_cnt      = 0;
  endtask

  task automatic drive_inputs();
    bit resp;
    resp = rom_pend && (rom_cnt == 0);
    rom_rvalid_in = resp || inject_rvalid;
    rom_rdata_in  = resp ? rom_word(rom_pend_addr) : $urandom();
    if (zero_wait) rom_ack_in = rom_req_out;
    else rom_ack_in = rom_req_out && (int'($urandom_range(0, 99)) < ack_pct);
    case (ready_mode)
      1:       id_ready_in = 1'b1;
      2:       id_ready_in = 1'b0;
      default: id_ready_in = (int'($urandom_range(0, 99)) < ready_pct);
    endcase
    if (jump_force) begin
      jump_flag_in = 1'b1;
      jump_addr_in = jump_tgt;
    end else if (int'($urandom_range(0, 99)) < jump_pct) begin
      jump_flag_in = 1'b1;
      jump_addr_in = $urandom();
    end else begin
      jump_flag_in = 1'b0;
      jump_addr_in = $urandom();
    end
  endtask

  task automatic check_and_update();
    logic [31:0] tgt;
    if (!if_valid_out) check_eq("nop_when_invalid", if_instr_out, NOP);
    if (prev_hold) begin
      check_eq("hold_valid", 32'(if_valid_out), 32'd1);
      check_eq("hold_pc", if_pc_out, prev_pc);
      check_eq("hold_instr", if_instr_out, prev_instr);
    end
    if (rom_req_out) begin
      check_eq("fetch_addr", rom_addr_out, exp_req_addr);
      check_eq("one_outstanding", 32'(rom_pend), 32'd0);
    end
    if (if_valid_out && id_ready_in) begin
      check_eq("out_pc", if_pc_out, exp_out_pc);
      check_eq("out_instr", if_instr_out, rom_word(exp_out_pc));
      exp_out_pc = exp_out_pc + 32'd4;
      n_xfer++;
    end
    tgt = {jump_addr_in[31:2], 2'b00};
    if (jump_flag_in) begin
      exp_out_pc   = tgt;
      exp_req_addr = tgt;
    end else if (rom_req_out && rom_ack_in) begin
      exp_req_addr = exp_req_addr + 32'd4;
    end
    prev_hold  = if_valid_out && !id_ready_in && !jump_flag_in;
    prev_pc    = if_pc_out;
    prev_instr = if_instr_out;
    if (rom_pend && rom_cnt == 0 && rom_rvalid_in) rom_pend = 1'b0;
    else if (rom_pend) rom_cnt--;
    if (rom_req_out && rom_ack_in) begin
      rom_pend      = 1'b1;
      rom_pend_addr = rom_addr_out;
      rom_cnt       = zero_wait ? 0 : ((rom_lat < 0) ? int'($urandom_range(0, 3)) : rom_lat);
    end
    inject_rvalid = 1'b0;
  endtask

  task automatic step();
    drive_inputs();
    #1;
    check_and_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump_flag_in  = 1'b0;
    rom_ack_in    = 1'b0;
    rom_rvalid_in = 1'b0;
    id_ready_in   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int xfer_before;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(rom_req_out), 32'd0);
    check_eq("rst_addr", rom_addr_out, 32'd0);
    check_eq("rst_valid", 32'(if_valid_out), 32'd0);
    check_eq("rst_instr", if_instr_out, NOP);
    check_eq("rst_pc", if_pc_out, 32'd0);
    check_eq("rst_wrap_addr", wr_addr, 32'd0);
    rst = 1'b0;

    // zero-wait ROM, always ready: fetch every 2 cycles, first output at cycle 3
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 1) begin
        check_eq("a_req", 32'(rom_req_out), 32'd1);
        check_eq("a_addr", rom_addr_out, 32'(c / 2) * 4);
        check_eq("a_wrap_addr", wr_addr, WRAP_PC + 32'(c / 2) * 4);
      end else begin
        check_eq("a_req_gap", 32'(rom_req_out), 32'd0);
      end
      if (c >= 3 && c % 2 == 1) begin
        check_eq("a_valid", 32'(if_valid_out), 32'd1);
        check_eq("a_pc", if_pc_out, 32'((c - 3) / 2) * 4);
      end else begin
        check_eq("a_valid_gap", 32'(if_valid_out), 32'd0);
      end
      step();
    end

    // downstream stall for 6 cycles: skid fills, no requests, order preserved
    do_reset();
    for (int c = 0; c < 14; c++) begin
      ready_mode = (c >= 3 && c <= 8) ? 2 : 1;
      if (c >= 4 && c <= 8) begin
        check_eq("b_no_req", 32'(rom_req_out), 32'd0);
        check_eq("b_hold_valid", 32'(if_valid_out), 32'd1);
        check_eq("b_hold_pc", if_pc_out, 32'd0);
      end
      if (c == 10 || c == 12) begin
        check_eq("b_valid", 32'(if_valid_out), 32'd1);
        check_eq("b_pc", if_pc_out, (c == 10) ? 32'd4 : 32'd8);
      end
      step();
    end
    ready_mode = 1;

    // jump in WAIT without response: drain, refetch at aligned target
    do_reset();
    zero_wait = 1'b0;
    ack_pct   = 100;
    rom_lat   = 2;
    for (int c = 0; c < 11; c++) begin
      jump_force = (c == 2);
      jump_tgt   = 32'h0000_0102;
      if (c == 4) check_eq("c_no_valid", 32'(if_valid_out), 32'd0);
      if (c == 5) begin
        check_eq("c_req", 32'(rom_req_out), 32'd1);
        check_eq("c_addr", rom_addr_out, 32'h0000_0100);
      end
      if (c == 9) begin
        check_eq("c_valid", 32'(if_valid_out), 32'd1);
        check_eq("c_pc", if_pc_out, 32'h0000_0100);
      end
      step();
    end
    jump_force = 1'b0;

    // jump coincident with rvalid, then with ack
    for (int run = 0; run < 2; run++) begin
      logic [31:0] tgt;
      tgt = (run == 0) ? 32'h0000_0200 : 32'h0000_0300;
      do_reset();
      zero_wait = 1'b1;
      for (int c = 0; c < 7; c++) begin
        jump_force = (c == ((run == 0) ? 2 : 1));
        jump_tgt   = tgt | 32'd1;
        if (c == 3) begin
          check_eq("d_req", 32'(rom_req_out), 32'd1);
          check_eq("d_addr", rom_addr_out, tgt);
          check_eq("d_no_stale", 32'(if_valid_out), 32'd0);
        end
        if (c == 5) begin
          check_eq("d_valid", 32'(if_valid_out), 32'd1);
          check_eq("d_pc", if_pc_out, tgt);
        end
        step();
      end
      jump_force = 1'b0;
    end

    // reset mid-WAIT with response pending and output held, then late rvalid in IDLE
    do_reset();
    zero_wait = 1'b0;
    rom_lat   = 2;
    for (int c = 0; c < 6; c++) begin
      ready_mode = (c >= 5) ? 2 : 1;
      step();
    end
    check_eq("e_pre_valid", 32'(if_valid_out), 32'd1);
    rom_ack_in    = 1'b0;
    rom_rvalid_in = 1'b0;
    jump_flag_in  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("e_req", 32'(rom_req_out), 32'd0);
    check_eq("e_addr", rom_addr_out, 32'd0);
    check_eq("e_valid", 32'(if_valid_out), 32'd0);
    check_eq("e_instr", if_instr_out, NOP);
    check_eq("e_pc", if_pc_out, 32'd0);
    model_reset();
    zero_wait  = 1'b1;
    rom_lat    = 0;
    ready_mode = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    inject_rvalid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin
        check_eq("e_restart_req", 32'(rom_req_out), 32'd1);
        check_eq("e_restart_addr", rom_addr_out, RST_PC);
      end
      if (c == 3) begin
        check_eq("e_first_valid", 32'(if_valid_out), 32'd1);
        check_eq("e_first_pc", if_pc_out, RST_PC);
        check_eq("e_first_instr", if_instr_out, rom_word(RST_PC));
      end
      step();
    end

    // randomized ROM latency, ack, backpressure and jumps
    do_reset();
    zero_wait  = 1'b0;
    ack_pct    = 60;
    rom_lat    = -1;
    ready_mode = 0;
    ready_pct  = 70;
    jump_pct   = 4;
    xfer_before = n_xfer;
    repeat (3000) step();
    check_eq("f_progress", 32'((n_xfer - xfer_before) > 150), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
